// File: rtl/m6502_fetch_sequencer_pkg.sv
// Shared definitions for the M6502 fetch sequencer and its decoder:
// timing-ring bit positions, the reset opcode and the decoder enable-bus layout.
package m6502_fetch_sequencer_pkg;

  // Bit positions inside the one-hot timing ring (bit n = Tn)
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int T6 = 6;
  localparam int T7 = 7;

  localparam int TIMING_W = 8;
  localparam logic [TIMING_W-1:0] TIMING_T0 = 8'h01;

  // Opcode register contents after reset
  localparam logic [7:0] NOP_OPCODE = 8'hEA;

  // Decoder enable-bus bit positions; the decoder packs its outputs this way
  localparam int TIMING_RESET = 0;
  localparam int WRITE_EN     = 1;
  localparam int PC_INC       = 2;
  localparam int RA_DATA_IN_Q = 3;
  localparam int ADL_LOAD     = 4;
  localparam int PC_LOAD      = 5;
  localparam int ENABLE_W     = 6;

endpackage

// File: rtl/m6502_timing_ring.sv
// One-hot T0..T7 timing ring. Advances each ready cycle, returns to T0 on
// timing_reset (ignored while in T0, where the decoder output is stale) and
// flags a sticky error when it has to wrap past T7 on its own.
module m6502_timing_ring
  import m6502_fetch_sequencer_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ready,
  input  logic                advance,
  input  logic                timing_reset,
  output logic [TIMING_W-1:0] timing,
  output logic                timing_error
);

  logic [TIMING_W-1:0] timing_next;
  logic                error_next;
  logic                step;
  logic                reset_ring;

  assign step       = ready & advance;
  // In T0 the enables come from the previous opcode, so they must not act
  assign reset_ring = timing_reset & ~timing[T0];

  // Next ring position: shift left, or return to T0 on reset / overrun
  always_comb begin
    timing_next = timing;
    error_next  = timing_error;
    if (step) begin
      if (reset_ring) begin
        timing_next = TIMING_T0;
      end else if (timing[T7]) begin
        timing_next = TIMING_T0;
        error_next  = 1'b1;
      end else begin
        timing_next = {timing[TIMING_W-2:0], 1'b0};
      end
    end
  end

  // Ring and sticky error registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timing       <= TIMING_T0;
      timing_error <= 1'b0;
    end else begin
      timing       <= timing_next;
      timing_error <= error_next;
    end
  end

endmodule

// File: rtl/m6502_fetch_sequencer.sv
// M6502 fetch sequencer: timing ring, opcode register, program counter and
// absolute-address low-byte latch, driven by the decoder's enables.
module m6502_fetch_sequencer
  import m6502_fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'hF000,
  parameter logic [7:0]  NOP_OPCODE = m6502_fetch_sequencer_pkg::NOP_OPCODE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ready,
  input  logic [7:0]  data_in,
  input  logic        timing_reset,
  input  logic        pc_inc,
  input  logic        adl_load,
  input  logic        pc_load,
  output logic [7:0]  timing,
  output logic [7:0]  opcode,
  output logic [15:0] address,
  output logic        sync,
  output logic [15:0] pc,
  output logic        timing_error
);

  logic [7:0] adl;
  logic       fetch;

  m6502_timing_ring u_ring (
    .clock        (clock),
    .reset_n      (reset_n),
    .ready        (ready),
    .advance      (1'b1),
    .timing_reset (timing_reset),
    .timing       (timing),
    .timing_error (timing_error)
  );

  assign fetch   = timing[T0];
  assign sync    = fetch;
  assign address = pc;

  // Opcode fetch in T0; PC load/increment and ADL latch in T1..T7
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opcode <= NOP_OPCODE;
      pc     <= RESET_PC;
      adl    <= 8'h00;
    end else if (ready) begin
      if (fetch) begin
        opcode <= data_in;
        pc     <= pc + 16'd1;
      end else begin
        if (pc_load) begin
          pc <= {data_in, adl};
        end else if (pc_inc) begin
          pc <= pc + 16'd1;
        end
        if (adl_load) begin
          adl <= data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_m6502_fetch_sequencer.sv
// Bench for m6502_fetch_sequencer: memory and decoder models around the DUT,
// per-cycle expectations queued as each cycle is driven and checked after it.
module tb_m6502_fetch_sequencer;
  import m6502_fetch_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ready;
  logic [7:0]  data_in;
  logic        timing_reset;
  logic        pc_inc;
  logic        adl_load;
  logic        pc_load;
  logic [7:0]  timing;
  logic [7:0]  opcode;
  logic [15:0] address;
  logic        sync;
  logic [15:0] pc;
  logic        timing_error;

  logic [7:0]          mem [0:65535];
  logic [ENABLE_W-1:0] en;

  typedef struct {
    logic [7:0]  timing;
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  m6502_fetch_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ready        (ready),
    .data_in      (data_in),
    .timing_reset (timing_reset),
    .pc_inc       (pc_inc),
    .adl_load     (adl_load),
    .pc_load      (pc_load),
    .timing       (timing),
    .opcode       (opcode),
    .address      (address),
    .sync         (sync),
    .pc           (pc),
    .timing_error (timing_error)
  );

  assign data_in = mem[address];

  // Decoder model. 8'hFF is a bench-only opcode asserting timing_reset and
  // pc_load in every state, to show that T0 ignores stale enables.
  always_comb begin
    en = '0;
    case (opcode)
      8'hEA, 8'hA9: begin
        if (timing[1]) begin
          en[PC_INC]       = 1'b1;
          en[TIMING_RESET] = 1'b1;
        end
      end
      8'h4C: begin
        if (timing[1]) begin
          en[ADL_LOAD] = 1'b1;
          en[PC_INC]   = 1'b1;
        end
        if (timing[2]) begin
          en[PC_LOAD]      = 1'b1;
          en[PC_INC]       = 1'b1;
          en[TIMING_RESET] = 1'b1;
        end
      end
      8'hFF: begin
        en[PC_LOAD]      = 1'b1;
        en[TIMING_RESET] = 1'b1;
      end
      default: ;
    endcase
  end

  assign timing_reset = en[TIMING_RESET];
  assign pc_inc       = en[PC_INC];
  assign adl_load     = en[ADL_LOAD];
  assign pc_load      = en[PC_LOAD];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_mem(input logic [7:0] val);
    for (int i = 0; i < 65536; i++) mem[i] = val;
  endtask

  // Hold reset across an edge, release mid-cycle and check reset state
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    #1;
    check("rst_timing", {24'd0, timing}, 32'h01);
    check("rst_pc", {16'd0, pc}, 32'hF000);
    check("rst_opcode", {24'd0, opcode}, 32'hEA);
    check("rst_error", {31'd0, timing_error}, 32'd0);
  endtask

  // Drive one cycle, queue its expected outcome, then check after the edge
  task automatic cyc(input string tag, input logic rdy, input logic [7:0] t,
                     input logic [15:0] p, input logic [7:0] op, input logic e);
    exp_t x;
    ready = rdy;
    x = '{t, p, op, e};
    sb.push_back(x);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    check({tag, "_timing"}, {24'd0, timing}, {24'd0, x.timing});
    check({tag, "_pc"}, {16'd0, pc}, {16'd0, x.pc});
    check({tag, "_address"}, {16'd0, address}, {16'd0, x.pc});
    check({tag, "_opcode"}, {24'd0, opcode}, {24'd0, x.opcode});
    check({tag, "_sync"}, {31'd0, sync}, {31'd0, x.timing[0]});
    check({tag, "_error"}, {31'd0, timing_error}, {31'd0, x.err});
  endtask

  initial begin
    reset_n = 1'b0;
    ready   = 1'b1;
    fill_mem(8'hEA);

    // NOP stream
    do_reset();
    cyc("nop0", 1'b1, 8'h02, 16'hF001, 8'hEA, 1'b0);
    cyc("nop1", 1'b1, 8'h01, 16'hF002, 8'hEA, 1'b0);
    cyc("nop2", 1'b1, 8'h02, 16'hF003, 8'hEA, 1'b0);
    cyc("nop3", 1'b1, 8'h01, 16'hF004, 8'hEA, 1'b0);

    // LDA #$42
    mem[16'hF000] = 8'hA9;
    mem[16'hF001] = 8'h42;
    do_reset();
    cyc("lda0", 1'b1, 8'h02, 16'hF001, 8'hA9, 1'b0);
    cyc("lda1", 1'b1, 8'h01, 16'hF002, 8'hA9, 1'b0);
    cyc("lda2", 1'b1, 8'h02, 16'hF003, 8'hEA, 1'b0);

    // LDA # with ready low for three cycles in T1
    do_reset();
    cyc("stl0", 1'b1, 8'h02, 16'hF001, 8'hA9, 1'b0);
    cyc("stl1", 1'b0, 8'h02, 16'hF001, 8'hA9, 1'b0);
    cyc("stl2", 1'b0, 8'h02, 16'hF001, 8'hA9, 1'b0);
    cyc("stl3", 1'b0, 8'h02, 16'hF001, 8'hA9, 1'b0);
    cyc("stl4", 1'b1, 8'h01, 16'hF002, 8'hA9, 1'b0);
    cyc("stl5", 1'b1, 8'h02, 16'hF003, 8'hEA, 1'b0);

    // JMP $1234
    fill_mem(8'hEA);
    mem[16'hF000] = 8'h4C;
    mem[16'hF001] = 8'h34;
    mem[16'hF002] = 8'h12;
    do_reset();
    cyc("jmp0", 1'b1, 8'h02, 16'hF001, 8'h4C, 1'b0);
    cyc("jmp1", 1'b1, 8'h04, 16'hF002, 8'h4C, 1'b0);
    cyc("jmp2", 1'b1, 8'h01, 16'h1234, 8'h4C, 1'b0);
    cyc("jmp3", 1'b1, 8'h02, 16'h1235, 8'hEA, 1'b0);

    // Asynchronous reset in T2 of JMP, no clock edge involved
    do_reset();
    cyc("ar0", 1'b1, 8'h02, 16'hF001, 8'h4C, 1'b0);
    cyc("ar1", 1'b1, 8'h04, 16'hF002, 8'h4C, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_timing", {24'd0, timing}, 32'h01);
    check("async_pc", {16'd0, pc}, 32'hF000);
    check("async_address", {16'd0, address}, 32'hF000);
    check("async_opcode", {24'd0, opcode}, 32'hEA);
    #2;
    reset_n = 1'b1;
    cyc("ar2", 1'b1, 8'h02, 16'hF001, 8'h4C, 1'b0);

    // JMP $FFFF then PC wraps to $0000
    fill_mem(8'hEA);
    mem[16'hF000] = 8'h4C;
    mem[16'hF001] = 8'hFF;
    mem[16'hF002] = 8'hFF;
    do_reset();
    cyc("wrp0", 1'b1, 8'h02, 16'hF001, 8'h4C, 1'b0);
    cyc("wrp1", 1'b1, 8'h04, 16'hF002, 8'h4C, 1'b0);
    cyc("wrp2", 1'b1, 8'h01, 16'hFFFF, 8'h4C, 1'b0);
    cyc("wrp3", 1'b1, 8'h02, 16'h0000, 8'hEA, 1'b0);
    cyc("wrp4", 1'b1, 8'h01, 16'h0001, 8'hEA, 1'b0);

    // Stale enables in T0 must be ignored; pc_load in T1 takes {data_in, adl}
    fill_mem(8'hEA);
    mem[16'hF000] = 8'hFF;
    do_reset();
    cyc("msk0", 1'b1, 8'h02, 16'hF001, 8'hFF, 1'b0);
    cyc("msk1", 1'b1, 8'h01, 16'hEA00, 8'hFF, 1'b0);
    cyc("msk2", 1'b1, 8'h02, 16'hEA01, 8'hEA, 1'b0);
    cyc("msk3", 1'b1, 8'h01, 16'hEA02, 8'hEA, 1'b0);

    // No timing_reset ever: ring overruns T7, error flag sticks
    fill_mem(8'h02);
    do_reset();
    cyc("ovr0", 1'b1, 8'h02, 16'hF001, 8'h02, 1'b0);
    cyc("ovr1", 1'b1, 8'h04, 16'hF001, 8'h02, 1'b0);
    cyc("ovr2", 1'b1, 8'h08, 16'hF001, 8'h02, 1'b0);
    cyc("ovr3", 1'b1, 8'h10, 16'hF001, 8'h02, 1'b0);
    cyc("ovr4", 1'b1, 8'h20, 16'hF001, 8'h02, 1'b0);
    cyc("ovr5", 1'b1, 8'h40, 16'hF001, 8'h02, 1'b0);
    cyc("ovr6", 1'b1, 8'h80, 16'hF001, 8'h02, 1'b0);
    cyc("ovr7", 1'b1, 8'h01, 16'hF001, 8'h02, 1'b1);
    cyc("ovr8", 1'b1, 8'h02, 16'hF002, 8'h02, 1'b1);
    cyc("ovr9", 1'b0, 8'h02, 16'hF002, 8'h02, 1'b1);
    cyc("ovrA", 1'b1, 8'h04, 16'hF002, 8'h02, 1'b1);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
